// File: rtl/i2s_square_tone_gen_pkg.sv
// I2S framing constants, FSM state type and the saturating negate shared by the tone generator.
package i2s_pkg;

  // The data word starts this many bit slots after the lrck transition.
  localparam int unsigned I2S_DATA_DELAY = 1;
  localparam logic        LRCK_LEFT      = 1'b0;
  localparam logic        LRCK_RIGHT     = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_t;

  // Two's-complement negate of a w-bit value held in the low bits of amp; the
  // most negative code has no positive twin, so it clamps to the largest positive.
  function automatic logic [31:0] sat_neg(input logic [31:0] amp, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] a;
    logic [31:0] mn;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a    = amp & mask;
    mn   = 32'd1 << (w - 1);
    if (a == mn) return mn - 32'd1;
    return (~a + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/i2s_square_tone_gen_if.sv
// Serial I2S output bundle of the square tone generator.
interface i2s_square_tone_gen_if;
  logic bck;
  logic lrck;
  logic data;
  logic frame_strb;

  modport master (output bck, lrck, data, frame_strb);
  modport slave  (input  bck, lrck, data, frame_strb);
endinterface

// File: rtl/i2s_square_tone_gen_sq_chan.sv
// One square-wave channel: frame counter, phase bit and the per-frame sample latch.
module sq_chan
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_latch,
  input  logic [SAMPLE_W-1:0] i_amp,
  input  logic [PERIOD_W-1:0] i_half,
  output logic [SAMPLE_W-1:0] o_sample
);

  logic [PERIOD_W-1:0] r_half;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;
  logic [SAMPLE_W-1:0] r_sample;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic                w_phase_nxt;

  // Closes out the previous frame with the half-period it was played with;
  // a shortened half-period wraps as soon as the count has reached it.
  always_comb begin
    w_cnt_nxt   = r_cnt + PERIOD_W'(1);
    w_phase_nxt = r_phase;
    if (r_half == '0) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (r_cnt >= r_half - PERIOD_W'(1)) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = ~r_phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half   <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_sample <= '0;
    end else if (i_latch) begin
      r_half <= i_half;
      if (i_half == '0) begin
        r_cnt    <= '0;
        r_phase  <= 1'b0;
        r_sample <= '0;
      end else begin
        r_cnt    <= w_cnt_nxt;
        r_phase  <= w_phase_nxt;
        r_sample <= w_phase_nxt ? SAMPLE_W'(sat_neg(32'(i_amp), SAMPLE_W)) : i_amp;
      end
    end
  end

  assign o_sample = r_sample;

endmodule

// File: rtl/i2s_square_tone_gen.sv
// Stereo square-tone I2S source; bck/lrck/data are all registers in the clk domain.
//   state   | meaning
//   ST_IDLE | outputs parked at 0, waiting for enable to start a frame
//   ST_RUN  | serialising a frame of 2*SLOT_W bit slots
module i2s_square_tone_gen
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CLK_DIV  = 2,
  parameter int PERIOD_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [SAMPLE_W-1:0]  amp_l,
  input  logic [SAMPLE_W-1:0]  amp_r,
  input  logic [PERIOD_W-1:0]  half_l,
  input  logic [PERIOD_W-1:0]  half_r,
  i2s_square_tone_gen_if.master i2s
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int POS_W = $clog2(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SLOT_W - 1);
  localparam logic [POS_W-1:0] POS_MSB  = POS_W'(I2S_DATA_DELAY);

  i2s_state_t          r_state;
  logic [DIV_W-1:0]    r_div;
  logic [POS_W-1:0]    r_pos;
  logic                r_bck;
  logic                r_lrck;
  logic                r_data;
  logic                r_strb;
  logic [SAMPLE_W-1:0] r_shift;

  logic                w_tick;
  logic                w_frame_end;
  logic                w_start;
  logic [SAMPLE_W-1:0] w_samp_l;
  logic [SAMPLE_W-1:0] w_samp_r;
  logic [SAMPLE_W-1:0] w_word;

  assign w_tick      = (r_state == ST_RUN) && (r_div == '0);
  assign w_frame_end = w_tick && r_bck && (r_lrck == LRCK_RIGHT) && (r_pos == POS_LAST);
  assign w_start     = ((r_state == ST_IDLE) || w_frame_end) && enable;
  assign w_word      = (r_lrck == LRCK_RIGHT) ? w_samp_r : w_samp_l;

  sq_chan #(.SAMPLE_W(SAMPLE_W), .PERIOD_W(PERIOD_W)) u_chan_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_latch  (w_start),
    .i_amp    (amp_l),
    .i_half   (half_l),
    .o_sample (w_samp_l)
  );

  sq_chan #(.SAMPLE_W(SAMPLE_W), .PERIOD_W(PERIOD_W)) u_chan_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_latch  (w_start),
    .i_amp    (amp_r),
    .i_half   (half_r),
    .o_sample (w_samp_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_pos   <= '0;
      r_bck   <= 1'b0;
      r_lrck  <= LRCK_LEFT;
      r_data  <= 1'b0;
      r_strb  <= 1'b0;
      r_shift <= '0;
    end else begin
      r_strb <= w_start;
      if (w_start) begin
        r_state <= ST_RUN;
        r_div   <= DIV_LOAD;
        r_bck   <= 1'b0;
        r_pos   <= '0;
        r_lrck  <= LRCK_LEFT;
        r_data  <= 1'b0;
      end else if (w_frame_end) begin
        r_state <= ST_IDLE;
        r_div   <= '0;
        r_bck   <= 1'b0;
        r_pos   <= '0;
        r_lrck  <= LRCK_LEFT;
        r_data  <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (!w_tick) begin
          r_div <= r_div - DIV_W'(1);
        end else begin
          r_div <= DIV_LOAD;
          r_bck <= ~r_bck;
          // Falling bck edge: move to the next bit slot.
          if (r_bck) begin
            if (r_pos == POS_LAST) begin
              r_pos  <= '0;
              r_lrck <= LRCK_RIGHT;
              r_data <= 1'b0;
            end else begin
              r_pos <= r_pos + POS_W'(1);
              if (r_pos + POS_W'(1) == POS_MSB) begin
                r_data  <= w_word[SAMPLE_W-1];
                r_shift <= {w_word[SAMPLE_W-2:0], 1'b0};
              end else begin
                r_data  <= r_shift[SAMPLE_W-1];
                r_shift <= {r_shift[SAMPLE_W-2:0], 1'b0};
              end
            end
          end
        end
      end
    end
  end

  assign i2s.bck        = r_bck;
  assign i2s.lrck       = r_lrck;
  assign i2s.data       = r_data;
  assign i2s.frame_strb = r_strb;

endmodule

// File: tb/tb_i2s_square_tone_gen.sv
// Scoreboard bench: stimulus queues the expected stereo word per frame, a monitor deserialises I2S and compares.
module tb_i2s_square_tone_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] amp_l, amp_r;
  logic [11:0] half_l, half_r;

  i2s_square_tone_gen_if i2s_if ();

  i2s_square_tone_gen dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .amp_l  (amp_l),
    .amp_r  (amp_r),
    .half_l (half_l),
    .half_r (half_r),
    .i2s    (i2s_if)
  );

  logic bck, lrck, data, strb;
  assign bck  = i2s_if.bck;
  assign lrck = i2s_if.lrck;
  assign data = i2s_if.data;
  assign strb = i2s_if.frame_strb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_strb();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!strb && n < 1000);
    chk("frame_start_seen", 32'(strb), 32'd1);
  endtask

  task automatic frame(input logic [15:0] el, input logic [15:0] er);
    sb_q.push_back({el, er});
    wait_strb();
  endtask

  // Monitor
  logic        m_act = 1'b0;
  int          m_k, m_cyc, m_last, m_n = 0;
  logic [31:0] m_sl, m_sr, m_exp;
  logic        m_lr_bad, m_per_bad, m_edge_bad;
  logic        pb = 1'b0, pl = 1'b0, pd = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_act = 1'b0;
        pb = 1'b0; pl = 1'b0; pd = 1'b0;
      end else begin
        if (strb) begin
          m_act = 1'b1; m_k = 0; m_cyc = 0; m_last = -1;
          m_sl = '0; m_sr = '0;
          m_lr_bad = 1'b0; m_per_bad = 1'b0; m_edge_bad = 1'b0;
        end
        m_cyc++;
        if (m_act) begin
          if (((lrck !== pl) || (data !== pd)) && !(pb && !bck)) m_edge_bad = 1'b1;
          if (bck && !pb) begin
            if (m_last >= 0 && (m_cyc - m_last) != 4) m_per_bad = 1'b1;
            m_last = m_cyc;
            if (lrck !== (m_k >= 32)) m_lr_bad = 1'b1;
            if (m_k < 32) m_sl = {m_sl[30:0], data};
            else          m_sr = {m_sr[30:0], data};
            m_k++;
            if (m_k == 64) begin
              m_act = 1'b0;
              if (sb_q.size() == 0) begin
                chk($sformatf("unexpected_frame f%0d", m_n), 32'd1, 32'd0);
              end else begin
                m_exp = sb_q.pop_front();
                chk($sformatf("left_word f%0d", m_n),  32'(m_sl[30:15]), 32'(m_exp[31:16]));
                chk($sformatf("right_word f%0d", m_n), 32'(m_sr[30:15]), 32'(m_exp[15:0]));
                chk($sformatf("pad_bits f%0d", m_n), {m_sl[31], m_sl[14:0], m_sr[31], m_sr[14:0]}, 32'd0);
                chk($sformatf("lrck_pattern f%0d", m_n), 32'(m_lr_bad), 32'd0);
                chk($sformatf("bck_period f%0d", m_n), 32'(m_per_bad), 32'd0);
                chk($sformatf("edge_align f%0d", m_n), 32'(m_edge_bad), 32'd0);
              end
              m_n++;
            end
          end
        end
        pb = bck; pl = lrck; pd = data;
      end
    end
  end

  logic [15:0] exp_d_l [11] = '{16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0123,
                                16'hFEDD, 16'hFEDD, 16'h0123, 16'h0123, 16'hFEDD};
  logic [15:0] exp_d_r [11] = '{16'h0040, 16'h0040, 16'h0040, 16'hFFC0, 16'hFFC0, 16'hFFC0,
                                16'h0040, 16'h0040, 16'h0040, 16'hFFC0, 16'hFFC0};
  logic idle_bad;

  initial begin
    rst_n = 1'b1; enable = 1'b0;
    amp_l = '0; amp_r = '0; half_l = '0; half_r = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bck, lrck, data, strb}), 32'd0);

    // Left half=4 square, right half=1 with saturating negate of 8000.
    amp_l = 16'h7FF5; half_l = 12'd4; amp_r = 16'h8000; half_r = 12'd1;
    enable = 1'b1; rst_n = 1'b1;
    for (int f = 0; f < 12; f++)
      frame(((f / 4) % 2) ? 16'h800B : 16'h7FF5, (f % 2) ? 16'h7FFF : 16'h8000);

    // Drop enable mid-frame: frame completes, then the bus stays quiet.
    enable = 1'b0;
    repeat (300) @(negedge clk);
    idle_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bck || lrck || data || strb) idle_bad = 1'b1;
    end
    chk("idle_quiet", 32'(idle_bad), 32'd0);

    // Re-enable: phases continue where they left off.
    enable = 1'b1;
    for (int f = 12; f < 16; f++)
      frame(((f / 4) % 2) ? 16'h800B : 16'h7FF5, (f % 2) ? 16'h7FFF : 16'h8000);

    // Left muted, right unaffected.
    half_l = 12'd0; amp_l = 16'h1234;
    for (int f = 16; f < 20; f++)
      frame(16'h0000, (f % 2) ? 16'h7FFF : 16'h8000);

    // Left half 8 -> 2 at tone frame 5; right half 3.
    half_l = 12'd8; amp_l = 16'h0123; half_r = 12'd3; amp_r = 16'h0040;
    for (int t = 0; t < 11; t++) begin
      if (t == 5) half_l = 12'd2;
      frame(exp_d_l[t], exp_d_r[t]);
    end

    // Reset in the right slot of the next frame, which is therefore not expected.
    wait_strb();
    repeat (190) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 32'({bck, lrck, data, strb}), 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_hold", 32'({bck, lrck, data, strb}), 32'd0);
    rst_n = 1'b1;
    frame(16'h0123, 16'h0040);
    frame(16'h0123, 16'h0040);
    frame(16'hFEDD, 16'h0040);

    enable = 1'b0;
    repeat (400) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
